// File: rtl/two_bit_divide.sv
// Restoring 4b/2b divider for the board: start key -> 4 busy cycles -> Q/R held on LEDR.
// Start is seen SYNC_STAGES+1 edges after the key falls; starts during a division are dropped.
module two_bit_divide #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [5:0] SW,
    output logic [9:0] LEDR
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE,
        ERR
    } state_t;

    logic clk;
    logic rst_n;

    assign clk   = CLOCK_50;
    assign rst_n = KEY[0];

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_d;
    logic                   key_s;
    logic                   start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            key_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], KEY[1]};
            key_d  <= key_s;
        end
    end

    assign key_s = sync_q[SYNC_STAGES-1];
    assign start = key_d & ~key_s;

    state_t     state;
    logic [3:0] n_sh;
    logic [1:0] d_reg;
    logic [2:0] r;
    logic [3:0] q;
    logic [1:0] cnt;
    logic [3:0] q_res;
    logic [1:0] r_res;
    logic       err;
    logic       busy;

    logic [2:0] t;
    logic [2:0] r_nxt;
    logic       q_bit;
    logic [3:0] q_nxt;

    // r[2] is never set while r < D holds; folding it into the compare keeps
    // the step correct for any 3-bit remainder.
    always_comb begin
        t     = {r[1:0], n_sh[3]};
        r_nxt = t;
        q_bit = 1'b0;
        if (r[2] || (t >= {1'b0, d_reg})) begin
            r_nxt = t - {1'b0, d_reg};
            q_bit = 1'b1;
        end
        q_nxt = {q[2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            n_sh  <= '0;
            d_reg <= '0;
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
            q_res <= '0;
            r_res <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        n_sh  <= SW[3:0];
                        d_reg <= SW[5:4];
                        r     <= '0;
                        q     <= '0;
                        cnt   <= '0;
                        if (SW[5:4] == 2'd0) begin
                            state <= ERR;
                            q_res <= 4'hF;
                            r_res <= 2'd0;
                            err   <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    n_sh <= {n_sh[2:0], 1'b0};
                    r    <= r_nxt;
                    q    <= q_nxt;
                    cnt  <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        q_res <= q_nxt;
                        r_res <= r_nxt[1:0];
                        err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign LEDR = {busy, err, 2'b00, r_res, q_res};

endmodule

// File: tb/tb_two_bit_divide.sv
// Directed bench for two_bit_divide: reset, single/sweep divisions, divide-by-zero,
// key hold, ignored restart, bouncing key and mid-division reset.
module tb_two_bit_divide;

    logic       CLOCK_50 = 1'b0;
    logic [1:0] KEY;
    logic [5:0] SW;
    logic [9:0] LEDR;

    int passes = 0;
    int total  = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    two_bit_divide #(.SYNC_STAGES(2)) dut (
        .CLOCK_50(CLOCK_50),
        .KEY     (KEY),
        .SW      (SW),
        .LEDR    (LEDR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press at a falling edge, hold through the division, then release and let the synchroniser settle.
    task automatic run_div(input logic [3:0] n, input logic [1:0] d);
        logic [9:0] prev;
        int first;
        int cnt;
        logic [3:0] q_exp;
        logic [1:0] r_exp;
        q_exp = n / d;
        r_exp = 2'(n % d);
        @(negedge CLOCK_50);
        prev   = LEDR;
        SW     = {d, n};
        KEY[1] = 1'b0;
        first  = 0;
        cnt    = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLOCK_50);
            if (LEDR[9]) begin
                cnt++;
                if (first == 0) first = i;
            end
            if (i == 5) check($sformatf("hold_prev n=%0d d=%0d", n, d), LEDR[8:0], prev[8:0]);
        end
        check($sformatf("busy_start n=%0d d=%0d", n, d), first, 3);
        check($sformatf("busy_len n=%0d d=%0d", n, d), cnt, 4);
        check($sformatf("quot n=%0d d=%0d", n, d), LEDR[3:0], q_exp);
        check($sformatf("rem n=%0d d=%0d", n, d), LEDR[5:4], r_exp);
        check($sformatf("err_busy n=%0d d=%0d", n, d), LEDR[9:6], 4'b0000);
        KEY[1] = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic run_err(input logic [3:0] n);
        int cnt;
        @(negedge CLOCK_50);
        SW     = {2'd0, n};
        KEY[1] = 1'b0;
        cnt    = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            if (LEDR[9]) cnt++;
            if (i == 3) check("err_after_p", LEDR[8], 1'b1);
        end
        check("err_no_busy", cnt, 0);
        check("err_leds", LEDR, 10'h10F);
        KEY[1] = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    initial begin
        int rises;
        int cnt;
        logic last;

        KEY = 2'b10;
        SW  = 6'd0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_held", LEDR, 10'h000);
        KEY[0] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("idle_after_reset", LEDR, 10'h000);

        run_div(4'd9, 2'd3);
        check("n9d3", LEDR, 10'h003);
        run_div(4'd15, 2'd1);
        check("n15d1", LEDR, 10'h00F);
        run_div(4'd7, 2'd2);
        check("n7d2", LEDR, 10'h013);

        run_err(4'd6);
        run_div(4'd6, 2'd2);
        check("n6d2_after_err", LEDR, 10'h003);

        for (int d = 1; d <= 3; d++)
            for (int n = 0; n <= 15; n++)
                run_div(4'(n), 2'(d));

        // Key held low for 20 cycles: one division only.
        @(negedge CLOCK_50);
        SW     = {2'd1, 4'd5};
        KEY[1] = 1'b0;
        rises  = 0;
        last   = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge CLOCK_50);
            if (LEDR[9] && !last) rises++;
            last = LEDR[9];
        end
        check("hold20_one_div", rises, 1);
        check("hold20_result", LEDR, 10'h005);
        KEY[1] = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        // Short press for 13/2, then a second press with new operands lands mid-division.
        @(negedge CLOCK_50);
        SW     = {2'd2, 4'd13};
        KEY[1] = 1'b0;
        @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("short_press_busy", LEDR[9], 1'b1);
        KEY[1] = 1'b0;
        SW     = {2'd1, 4'd15};
        cnt    = 1;
        for (int i = 4; i <= 16; i++) begin
            @(negedge CLOCK_50);
            if (LEDR[9]) cnt++;
        end
        check("restart_ignored_busy", cnt, 4);
        check("latched_operands", LEDR, 10'h016);
        KEY[1] = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        // Bouncing key with sub-cycle glitches; operands equal the previous result's.
        run_div(4'd10, 2'd3);
        for (int c = 0; c < 30; c++) begin
            @(negedge CLOCK_50);
            check("bounce_no_x", 32'((^LEDR) === 1'bx), 32'd0);
            #1 KEY[1] = 1'($urandom);
            #1 KEY[1] = 1'($urandom);
            #1 KEY[1] = 1'($urandom);
        end
        KEY[1] = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        check("bounce_result", LEDR, 10'h013);

        // Reset during the second CALC cycle of 13/3.
        @(negedge CLOCK_50);
        SW     = {2'd3, 4'd13};
        KEY[1] = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        check("busy_before_rst", LEDR[9], 1'b1);
        KEY[0] = 1'b0;
        #1;
        check("rst_mid_calc", LEDR, 10'h000);
        KEY[1] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_mid_calc_held", LEDR, 10'h000);
        KEY[0] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        run_div(4'd13, 2'd3);
        check("n13d3_after_rst", LEDR, 10'h014);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/two_bit_divide.md
# two_bit_divide

Sequential restoring divider that inverts the board's 2×2-bit multiplier: it takes a 4-bit product and a 2-bit factor from the switches and recovers the other factor plus a remainder on the LEDs. A push-button starts each division. The result is computed one quotient bit per clock over four cycles, then held on LEDR until the next start. It is a top-level board block with the same SW/LEDR conventions as the multiplier, and adds the board clock and keys.

## Interface
- SYNC_STAGES, 2, number of flip-flop stages synchronising KEY[1] (minimum 2).
- CLOCK_50  input  1  board clock; all state updates on its rising edge.
- KEY[0]  input  1  reset; asynchronous, active-low; clears all state immediately.
- KEY[1]  input  1  start; active-low push-button, asynchronous to CLOCK_50.
- SW  input  6  SW[3:0] = dividend N (product), SW[5:4] = divisor D.
- LEDR  output  10  LEDR[3:0] = quotient Q; LEDR[5:4] = remainder R; LEDR[7:6] = 0; LEDR[8] = divide-by-zero error; LEDR[9] = busy.

## Operation
- Start detect:
  - KEY[1] passes through SYNC_STAGES flops, reset value 1.
  - A one-cycle start pulse is generated on the synchronised 1→0 transition.
  - Holding the key low gives exactly one pulse. Release gives none.
- FSM states: IDLE, CALC, DONE, ERR. Reset state is IDLE.
- IDLE/DONE/ERR on start pulse:
  - Latch SW[3:0] into the dividend shift register and SW[5:4] into the divisor register.
  - Clear the partial remainder register (3 bits) and the iteration counter (2 bits).
  - If SW[5:4]==0, go to ERR. Otherwise go to CALC.
- CALC, one step per cycle, MSB first:
  - t = {r[1:0], n[3]}; n shifts left.
  - If t ≥ {1'b0,D}: r = t − D and the quotient bit is 1. Else r = t and the quotient bit is 0.
  - The quotient bit shifts into the LSB of the quotient register.
  - After the 4th step (counter == 3), go to DONE.
- Width rule: the partial remainder is always < D ≤ 3. Its 3-bit width absorbs the shifted-in bit. The final R fits in 2 bits.
- Entry to DONE: the LEDR result register loads Q and R[1:0]; LEDR[8]=0.
- Entry to ERR: LEDR[3:0]=4'hF, LEDR[5:4]=0, LEDR[8]=1.
- Start pulses while in CALC are ignored (not queued).
- SW changes after the latch cycle have no effect on the running division.
- A new start from DONE/ERR re-runs the division. LEDR keeps its previous result until the new result loads. LEDR[8] clears only when a DONE result loads.

## Timing
- Reset (KEY[0]=0), asynchronous:
  - State IDLE; synchroniser flops = 1; all datapath registers = 0.
  - LEDR = 10'b0.
  - Applies mid-CALC too; no partial result is ever shown.
- Start latency: a KEY[1] falling edge yields a start pulse SYNC_STAGES+1 rising edges later (edge-detect register included).
- Start pulse sampled at edge p, valid divisor:
  - CALC during cycles p+1..p+4.
  - Result on LEDR and state DONE after edge p+4.
  - LEDR[9]=1 exactly for cycles p+1..p+4.
- Start pulse sampled at edge p, divisor 0: ERR values on LEDR after edge p. LEDR[9] stays 0.
- LEDR is fully registered; no combinational path from SW or KEY to LEDR.

## Test plan
- Reset, then N=9, D=3, press start → after 4 busy cycles LEDR[3:0]=3, LEDR[5:4]=0, LEDR[8]=0, LEDR[9]=0. Also check LEDR=0 while reset is held.
- Sweep every N in 0..15 and D in 1..3 → Q=N/D, R=N%D, busy high exactly 4 cycles. Includes N=15, D=1 → Q=15, R=0 and N=7, D=2 → Q=3, R=1.
- N=6, D=0, start → LEDR[3:0]=F, LEDR[5:4]=0, LEDR[8]=1, no busy. Then N=6, D=2, start → Q=3, R=0, LEDR[8]=0.
- Hold KEY[1] low for 20 cycles → exactly one division. Second press with SW changed mid-CALC → the first result reflects the latched operands; a start during CALC is ignored.
- Bounce KEY[1] asynchronously with sub-cycle glitches → no X on LEDR; each clean low level yields at most one start.
- Assert KEY[0] during the 2nd CALC cycle of N=13, D=3 → LEDR=0 and IDLE immediately. After release and a new start → Q=4, R=1.
